// File: rtl/prt_dptx_trn_pkg.sv
// Shared types, symbol constants and pattern tables for the DP TX training generator.
// Optional TPS4 support is selected by the PRT_DPTX_TRN_TPS4_EN macro.
package prt_dptx_trn_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TPS1 = 3'd1,
        TPS2 = 3'd2,
        TPS3 = 3'd3,
        TPS4 = 3'd4
    } tps_t;

    localparam logic [7:0] SYM_D10_2  = 8'h4A;
    localparam logic [7:0] SYM_D11_6  = 8'hCB;
    localparam logic [7:0] SYM_K28_5  = 8'hBC;
    localparam logic [3:0] TRN_PERIOD = 4'd10;

    // Entries are {k, dat}, index 0 first.
    localparam logic [8:0] TPS2_SEQ [0:9] = '{
        {1'b1, SYM_K28_5}, {1'b0, SYM_D11_6}, {1'b1, SYM_K28_5}, {1'b0, SYM_D11_6},
        {1'b0, SYM_D10_2}, {1'b0, SYM_D10_2}, {1'b0, SYM_D10_2}, {1'b0, SYM_D10_2},
        {1'b0, SYM_D10_2}, {1'b0, SYM_D10_2}
    };

    localparam logic [8:0] TPS3_SEQ [0:9] = '{
        {1'b1, SYM_K28_5}, {1'b0, SYM_D11_6}, {1'b0, SYM_D10_2}, {1'b0, SYM_D10_2},
        {1'b1, SYM_K28_5}, {1'b0, SYM_D11_6}, {1'b0, SYM_D11_6}, {1'b0, SYM_D10_2},
        {1'b0, SYM_D10_2}, {1'b0, SYM_D10_2}
    };

    // Folds a value below 2*TRN_PERIOD back into 0..TRN_PERIOD-1.
    function automatic logic [3:0] trn_wrap(input logic [3:0] v);
        return (v >= TRN_PERIOD) ? (v - TRN_PERIOD) : v;
    endfunction

    function automatic tps_t tps_decode(input logic [2:0] code);
        tps_t t;
        case (code)
            3'd1:    t = TPS1;
            3'd2:    t = TPS2;
            3'd3:    t = TPS3;
`ifdef PRT_DPTX_TRN_TPS4_EN
            3'd4:    t = TPS4;
`endif
            default: t = IDLE;
        endcase
        return t;
    endfunction

    function automatic logic [2:0] lanes_decode(input logic [2:0] code);
        logic [2:0] n;
        case (code)
            3'd2:    n = 3'd2;
            3'd4:    n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/prt_dptx_trn_lane.sv
// One lane of the training generator: pattern index, symbol mux and output register.
// Scrambler pass-through exists only when PRT_DPTX_TRN_TPS4_EN is defined.
module prt_dptx_trn_lane
    import prt_dptx_trn_pkg::*;
#(
    parameter int P_SPL = 2
) (
    input  logic                 CLK_IN,
    input  logic                 RST_IN,
    input  logic [2:0]           state,
    input  logic                 lane_act,
    input  logic                 restart,
    input  logic [P_SPL-1:0]     lnk_k,
    input  logic [P_SPL*8-1:0]   lnk_dat,
    input  logic [P_SPL-1:0]     scrm_k,
    input  logic [P_SPL*8-1:0]   scrm_dat,
    output logic [P_SPL-1:0]     trn_k,
    output logic [P_SPL*8-1:0]   trn_dat
);

    tps_t                 state_s;
    logic [3:0]           idx_r;
    logic [3:0]           idx_nxt_s;
    logic [P_SPL-1:0]     k_nxt_s;
    logic [P_SPL*8-1:0]   dat_nxt_s;
    logic [P_SPL-1:0]     k_r;
    logic [P_SPL*8-1:0]   dat_r;

`ifndef PRT_DPTX_TRN_TPS4_EN
    logic unused_s;
    assign unused_s = ^{scrm_k, scrm_dat};
`endif

    assign state_s = tps_t'(state);

    // Index advances by the symbols emitted per clock, wrapping at the pattern period.
    always_comb begin
        idx_nxt_s = trn_wrap(idx_r + 4'(P_SPL));
    end

    // Per-slot symbol selection; inactive lanes are blanked only while training.
    always_comb begin
        k_nxt_s   = '0;
        dat_nxt_s = '0;
        for (int j = 0; j < P_SPL; j++) begin
            logic [8:0] sym_s;
            sym_s = 9'd0;
            case (state_s)
                IDLE:    sym_s = {lnk_k[j], lnk_dat[j*8 +: 8]};
                TPS1:    sym_s = {1'b0, SYM_D10_2};
                TPS2:    sym_s = TPS2_SEQ[trn_wrap(idx_r + 4'(j))];
                TPS3:    sym_s = TPS3_SEQ[trn_wrap(idx_r + 4'(j))];
`ifdef PRT_DPTX_TRN_TPS4_EN
                TPS4:    sym_s = {scrm_k[j], scrm_dat[j*8 +: 8]};
`endif
                default: sym_s = 9'd0;
            endcase
            if (lane_act || (state_s == IDLE)) begin
                k_nxt_s[j]          = sym_s[8];
                dat_nxt_s[j*8 +: 8] = sym_s[7:0];
            end else begin
                k_nxt_s[j]          = 1'b0;
                dat_nxt_s[j*8 +: 8] = 8'd0;
            end
        end
    end

    // Index counter and output register.
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            idx_r <= 4'd0;
            k_r   <= '0;
            dat_r <= '0;
        end else begin
            idx_r <= restart ? 4'd0 : idx_nxt_s;
            k_r   <= k_nxt_s;
            dat_r <= dat_nxt_s;
        end
    end

    assign trn_k   = k_r;
    assign trn_dat = dat_r;

endmodule

// File: rtl/prt_dptx_trn.sv
// DP TX link-training pattern generator top: config/state register, status and lane array.
// TPS4 (scrambler pass-through) is enabled by defining PRT_DPTX_TRN_TPS4_EN.
module prt_dptx_trn
    import prt_dptx_trn_pkg::*;
#(
    parameter int P_LANES = 2,
    parameter int P_SPL   = 2
) (
    input  logic                         CLK_IN,
    input  logic                         RST_IN,
    input  logic                         CFG_SET_IN,
    input  logic [2:0]                   CFG_TPS_IN,
    input  logic [2:0]                   CFG_LANES_IN,
    input  logic [P_LANES*P_SPL-1:0]     LNK_K_IN,
    input  logic [P_LANES*P_SPL*8-1:0]   LNK_DAT_IN,
    input  logic [P_LANES*P_SPL-1:0]     SCRM_K_IN,
    input  logic [P_LANES*P_SPL*8-1:0]   SCRM_DAT_IN,
    output logic [P_LANES*P_SPL-1:0]     LNK_K_OUT,
    output logic [P_LANES*P_SPL*8-1:0]   LNK_DAT_OUT,
    output logic                         STA_ACT_OUT,
    output logic [15:0]                  STA_CNT_OUT
);

    tps_t        state_r;
    tps_t        state_nxt_s;
    logic [2:0]  lanes_r;
    logic [2:0]  lanes_nxt_s;
    logic        act_r;
    logic [15:0] cnt_r;

    // Next-state: any state may jump to any other, but only on a config strobe.
    always_comb begin
        state_nxt_s = state_r;
        lanes_nxt_s = lanes_r;
        if (CFG_SET_IN) begin
            state_nxt_s = tps_decode(CFG_TPS_IN);
            lanes_nxt_s = lanes_decode(CFG_LANES_IN);
        end else begin
            state_nxt_s = state_r;
            lanes_nxt_s = lanes_r;
        end
    end

    // State, lane count and status registers; the counter saturates instead of wrapping.
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            state_r <= IDLE;
            lanes_r <= 3'd1;
            act_r   <= 1'b0;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            lanes_r <= lanes_nxt_s;
            act_r   <= (state_r != IDLE);
            if (CFG_SET_IN) begin
                cnt_r <= 16'd0;
            end else if ((state_r != IDLE) && (cnt_r != 16'hFFFF)) begin
                cnt_r <= cnt_r + 16'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    for (genvar l = 0; l < P_LANES; l++) begin : g_lane
        prt_dptx_trn_lane #(
            .P_SPL (P_SPL)
        ) u_lane (
            .CLK_IN   (CLK_IN),
            .RST_IN   (RST_IN),
            .state    (state_r),
            .lane_act (3'(l) < lanes_r),
            .restart  (CFG_SET_IN),
            .lnk_k    (LNK_K_IN[l*P_SPL +: P_SPL]),
            .lnk_dat  (LNK_DAT_IN[l*P_SPL*8 +: P_SPL*8]),
            .scrm_k   (SCRM_K_IN[l*P_SPL +: P_SPL]),
            .scrm_dat (SCRM_DAT_IN[l*P_SPL*8 +: P_SPL*8]),
            .trn_k    (LNK_K_OUT[l*P_SPL +: P_SPL]),
            .trn_dat  (LNK_DAT_OUT[l*P_SPL*8 +: P_SPL*8])
        );
    end

    assign STA_ACT_OUT = act_r;
    assign STA_CNT_OUT = cnt_r;

endmodule

// File: tb/tb_prt_dptx_trn.sv
// Randomized bench for prt_dptx_trn: two instances (4 lanes, 2 and 4 symbols/clock)
// checked every cycle against a time-indexed pattern model.
module tb_prt_dptx_trn;
    import prt_dptx_trn_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         cfg_set;
    logic [2:0]   cfg_tps;
    logic [2:0]   cfg_lanes;
    logic [15:0]  lnk_k, scrm_k;
    logic [127:0] lnk_dat, scrm_dat;
    logic [7:0]   k2;
    logic [63:0]  d2;
    logic [15:0]  k4;
    logic [127:0] d4;
    logic         act2, act4;
    logic [15:0]  cnt2, cnt4;

    prt_dptx_trn #(.P_LANES(4), .P_SPL(2)) u_dut2 (
        .CLK_IN(clk), .RST_IN(rst_n), .CFG_SET_IN(cfg_set), .CFG_TPS_IN(cfg_tps),
        .CFG_LANES_IN(cfg_lanes), .LNK_K_IN(lnk_k[7:0]), .LNK_DAT_IN(lnk_dat[63:0]),
        .SCRM_K_IN(scrm_k[7:0]), .SCRM_DAT_IN(scrm_dat[63:0]), .LNK_K_OUT(k2),
        .LNK_DAT_OUT(d2), .STA_ACT_OUT(act2), .STA_CNT_OUT(cnt2)
    );

    prt_dptx_trn #(.P_LANES(4), .P_SPL(4)) u_dut4 (
        .CLK_IN(clk), .RST_IN(rst_n), .CFG_SET_IN(cfg_set), .CFG_TPS_IN(cfg_tps),
        .CFG_LANES_IN(cfg_lanes), .LNK_K_IN(lnk_k), .LNK_DAT_IN(lnk_dat),
        .SCRM_K_IN(scrm_k), .SCRM_DAT_IN(scrm_dat), .LNK_K_OUT(k4),
        .LNK_DAT_OUT(d4), .STA_ACT_OUT(act4), .STA_CNT_OUT(cnt4)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: configured pattern, lane count, clocks since the last load, status count.
    int m_tps, m_lanes, m_t, m_cnt;
    bit fix_lnk = 1'b0;
    logic [8:0] ref_tps2 [10] = '{9'h1BC, 9'h0CB, 9'h1BC, 9'h0CB, 9'h04A,
                                  9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h04A};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic int model_tps(input int c);
`ifdef PRT_DPTX_TRN_TPS4_EN
        return (c <= 4) ? c : 0;
`else
        return (c <= 3) ? c : 0;
`endif
    endfunction

    // Expected {k, dat} for an instance with spl symbols/lane, from the pre-edge model state.
    function automatic logic [143:0] exp_vec(input int spl);
        logic [15:0]  ek = '0;
        logic [127:0] ed = '0;
        logic [8:0]   sym;
        for (int l = 0; l < 4; l++) begin
            for (int j = 0; j < spl; j++) begin
                int n = l * spl + j;
                int p = (m_t * spl + j) % 10;
                if (m_tps == 0)          sym = {lnk_k[n], lnk_dat[n*8 +: 8]};
                else if (l >= m_lanes)   sym = 9'd0;
                else if (m_tps == 1)     sym = 9'h04A;
                else if (m_tps == 2)     sym = ref_tps2[p];
                else if (m_tps == 3)     sym = TPS3_SEQ[p];
                else                     sym = {scrm_k[n], scrm_dat[n*8 +: 8]};
                ek[n]        = sym[8];
                ed[n*8 +: 8] = sym[7:0];
            end
        end
        return {ek, ed};
    endfunction

    task automatic step(input logic set, input logic [2:0] tps, input logic [2:0] lanes, input bit chk);
        logic [143:0] e2, e4;
        bit act_e;
        cfg_set   = set;
        cfg_tps   = tps;
        cfg_lanes = lanes;
        lnk_k     = 16'($urandom);
        scrm_k    = 16'($urandom);
        for (int w = 0; w < 4; w++) begin
            lnk_dat[w*32 +: 32]  = $urandom;
            scrm_dat[w*32 +: 32] = $urandom;
        end
        if (fix_lnk) lnk_dat[15:0] = 16'h1234;
        e2    = exp_vec(2);
        e4    = exp_vec(4);
        act_e = (m_tps != 0);
        if (set) begin
            m_tps   = model_tps(int'(tps));
            m_lanes = (lanes == 3'd2 || lanes == 3'd4) ? int'(lanes) : 1;
            m_t     = 0;
            m_cnt   = 0;
        end else begin
            m_t++;
            if (act_e && m_cnt < 65535) m_cnt++;
        end
        @(posedge clk);
        #1;
        cfg_set = 1'b0;
        if (chk) begin
            check("k_spl2",   {120'd0, k2},  {120'd0, e2[135:128]});
            check("dat_spl2", {64'd0, d2},   {64'd0, e2[63:0]});
            check("k_spl4",   {112'd0, k4},  {112'd0, e4[143:128]});
            check("dat_spl4", d4,            e4[127:0]);
            check("act",      {126'd0, act2, act4}, {126'd0, act_e, act_e});
            check("cnt",      {96'd0, cnt2, cnt4}, {96'd0, m_cnt[15:0], m_cnt[15:0]});
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_k"},   {104'd0, k2, k4}, 128'd0);
        check({tag, "_d2"},  {64'd0, d2}, 128'd0);
        check({tag, "_d4"},  d4, 128'd0);
        check({tag, "_sta"}, {94'd0, act2, act4, cnt2, cnt4}, 128'd0);
    endtask

    task automatic model_reset();
        m_tps = 0; m_lanes = 1; m_t = 0; m_cnt = 0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_set = 1'b0; cfg_tps = 3'd0; cfg_lanes = 3'd1;
        lnk_k = '0; scrm_k = '0; lnk_dat = '0; scrm_dat = '0;
        model_reset();
        #12;
        check_zero("reset");
        #1 rst_n = 1'b1;

        repeat (3) step(1'b0, 3'd0, 3'd0, 1'b1);
        fix_lnk = 1'b1;
        step(1'b0, 3'd0, 3'd0, 1'b1);
        fix_lnk = 1'b0;
        check("pass_1234", {112'd0, d2[15:0]}, 128'h1234);

        step(1'b1, 3'd1, 3'd2, 1'b1);
        repeat (8) step(1'b0, 3'd0, 3'd0, 1'b1);
        step(1'b1, 3'd2, 3'd4, 1'b1);
        repeat (3) step(1'b0, 3'd0, 3'd0, 1'b1);
        step(1'b1, 3'd2, 3'd4, 1'b1);
        repeat (14) step(1'b0, 3'd0, 3'd0, 1'b1);
        step(1'b1, 3'd3, 3'd1, 1'b1);
        repeat (12) step(1'b0, 3'd0, 3'd0, 1'b1);
        step(1'b1, 3'd4, 3'd2, 1'b1);
        repeat (5) step(1'b0, 3'd0, 3'd0, 1'b1);
        step(1'b1, 3'd6, 3'd3, 1'b1);
        repeat (4) step(1'b0, 3'd0, 3'd0, 1'b1);
        step(1'b1, 3'd2, 3'd7, 1'b1);
        repeat (4) step(1'b0, 3'd0, 3'd0, 1'b1);
        step(1'b1, 3'd2, 3'd4, 1'b1);
        step(1'b1, 3'd1, 3'd2, 1'b1);
        step(1'b1, 3'd3, 3'd4, 1'b1);
        repeat (12) step(1'b0, 3'd0, 3'd0, 1'b1);

        // Asynchronous reset in the middle of a running pattern.
        #2 rst_n = 1'b0;
        #1 check_zero("mid_reset");
        model_reset();
        #1 rst_n = 1'b1;
        repeat (3) step(1'b0, 3'd0, 3'd0, 1'b1);

        step(1'b1, 3'd1, 3'd4, 1'b1);
        repeat (70000) step(1'b0, 3'd0, 3'd0, 1'b0);
        repeat (3) step(1'b0, 3'd0, 3'd0, 1'b1);
        check("cnt_sat", {112'd0, cnt4}, 128'hFFFF);
        step(1'b1, 3'd0, 3'd1, 1'b1);
        repeat (4) step(1'b0, 3'd0, 3'd0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
